jelly_wishbone_regfile: RTL and testbench

JELLY_WISHBONE_REGFILE -- requirements
Module: jelly_wishbone_regfile

---
 rtl/jelly_wishbone_regfile_pkg.sv | 20 ++
 rtl/jelly_wishbone_wait_counter.sv | 36 +++
 rtl/jelly_wishbone_regfile.sv | 201 ++++++++++++++++++++
 tb/tb_jelly_wishbone_regfile.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/jelly_wishbone_regfile_pkg.sv
// rtl/jelly_wishbone_regfile_pkg.sv - shared FSM state type and address-map offsets for the Wishbone register file
package jelly_wishbone_regfile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } wb_state_t;

  // Word offsets of the read-only words, relative to NUM_REGS
  localparam int CNT_OFFSET     = 0;
  localparam int ID_OFFSET      = 1;
  localparam int WAIT_CNT_WIDTH = 4;

  // The accept edge already consumes one wait cycle, so the counter starts one lower
  function automatic logic [WAIT_CNT_WIDTH-1:0] wait_load_value(input int wait_cycles);
    return (wait_cycles > 0) ? WAIT_CNT_WIDTH'(wait_cycles - 1) : '0;
  endfunction

endpackage

// File: rtl/jelly_wishbone_wait_counter.sv
// rtl/jelly_wishbone_wait_counter.sv - down-counter timing the wait states of one transfer
module jelly_wishbone_wait_counter
  import jelly_wishbone_regfile_pkg::*;
#(
  parameter logic [WAIT_CNT_WIDTH-1:0] LOAD_VALUE = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  output logic done
);

  logic [WAIT_CNT_WIDTH-1:0] cnt_q;
  logic [WAIT_CNT_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VALUE;
    end else if (count && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/jelly_wishbone_regfile.sv
// rtl/jelly_wishbone_regfile.sv - Wishbone slave register file with wait states, cycle counter and ID word
// Optional error response for unmapped / read-only-write accesses: define JELLY_WB_REGFILE_ERR_EN.
module jelly_wishbone_regfile
  import jelly_wishbone_regfile_pkg::*;
#(
  parameter int                WB_ADR_WIDTH = 30,
  parameter int                WB_DAT_SIZE  = 2,
  parameter int                WB_DAT_WIDTH = (8 << WB_DAT_SIZE),
  parameter int                WB_SEL_WIDTH = WB_DAT_WIDTH / 8,
  parameter int                NUM_REGS     = 8,
  parameter int                WAIT_CYCLES  = 2,
  parameter logic [31:0]       ID_VALUE     = 32'h4A4C5246
) (
  input  logic                    s_wb_clk_i,
  input  logic                    s_wb_rst_i,
  input  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i,
  output logic [WB_DAT_WIDTH-1:0] s_wb_dat_o,
  input  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i,
  input  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i,
  input  logic                    s_wb_we_i,
  input  logic                    s_wb_stb_i,
  output logic                    s_wb_ack_o
`ifdef JELLY_WB_REGFILE_ERR_EN
  ,
  output logic                    s_wb_err_o
`endif
);

  wb_state_t state_q, state_d;

  logic [WB_ADR_WIDTH-1:0] adr_q, adr_d;
  logic [WB_DAT_WIDTH-1:0] dat_q, dat_d;
  logic [WB_SEL_WIDTH-1:0] sel_q, sel_d;
  logic                    we_q, we_d;

  logic [WB_DAT_WIDTH-1:0] regs_q [NUM_REGS];
  logic [WB_DAT_WIDTH-1:0] regs_d [NUM_REGS];
  logic [WB_DAT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WB_DAT_WIDTH-1:0] dat_o_q, dat_o_d;
  logic                    ack_q, ack_d;

  logic                    accept;
  logic                    enter_ack;
  logic                    wait_done;
  logic [WB_ADR_WIDTH-1:0] cur_adr;
  logic [WB_DAT_WIDTH-1:0] cur_dat;
  logic [WB_SEL_WIDTH-1:0] cur_sel;
  logic                    cur_we;
  logic                    is_rw;
  logic                    is_cnt;
  logic                    is_id;
  logic [WB_DAT_WIDTH-1:0] rdata;

  assign accept = (state_q == ST_IDLE) && s_wb_stb_i;

  jelly_wishbone_wait_counter #(
    .LOAD_VALUE (wait_load_value(WAIT_CYCLES))
  ) u_wait_counter (
    .clk   (s_wb_clk_i),
    .rst   (s_wb_rst_i),
    .load  (accept),
    .count (state_q == ST_WAIT),
    .done  (wait_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (s_wb_stb_i) begin
          state_d = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!s_wb_stb_i) begin
          state_d = ST_IDLE;
        end else if (wait_done) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign enter_ack = (state_d == ST_ACK);

  always_comb begin
    adr_d = adr_q;
    dat_d = dat_q;
    sel_d = sel_q;
    we_d  = we_q;
    if (accept) begin
      adr_d = s_wb_adr_i;
      dat_d = s_wb_dat_i;
      sel_d = s_wb_sel_i;
      we_d  = s_wb_we_i;
    end
  end

  // With zero wait states ACK is entered on the accept edge itself, before the latches update
  always_comb begin
    cur_adr = (state_q == ST_IDLE) ? s_wb_adr_i : adr_q;
    cur_dat = (state_q == ST_IDLE) ? s_wb_dat_i : dat_q;
    cur_sel = (state_q == ST_IDLE) ? s_wb_sel_i : sel_q;
    cur_we  = (state_q == ST_IDLE) ? s_wb_we_i  : we_q;
  end

  always_comb begin
    is_rw  = (cur_adr < WB_ADR_WIDTH'(NUM_REGS));
    is_cnt = (cur_adr == WB_ADR_WIDTH'(NUM_REGS + CNT_OFFSET));
    is_id  = (cur_adr == WB_ADR_WIDTH'(NUM_REGS + ID_OFFSET));
    rdata  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cur_adr == WB_ADR_WIDTH'(i)) begin
        rdata = regs_q[i];
      end
    end
    if (is_cnt) begin
      rdata = cnt_q;
    end
    if (is_id) begin
      rdata = WB_DAT_WIDTH'(ID_VALUE);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (enter_ack && cur_we && (cur_adr == WB_ADR_WIDTH'(i))) begin
        for (int b = 0; b < WB_SEL_WIDTH; b++) begin
          if (cur_sel[b]) begin
            regs_d[i][b*8 +: 8] = cur_dat[b*8 +: 8];
          end
        end
      end
    end
  end

`ifdef JELLY_WB_REGFILE_ERR_EN
  logic bad_access;
  logic err_q, err_d;

  always_comb begin
    bad_access = !(is_rw || is_cnt || is_id) || (cur_we && !is_rw);
    ack_d      = enter_ack && !bad_access;
    err_d      = enter_ack && bad_access;
  end

  always_ff @(posedge s_wb_clk_i or posedge s_wb_rst_i) begin
    if (s_wb_rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign s_wb_err_o = err_q;
`else
  always_comb begin
    ack_d = enter_ack;
  end
`endif

  always_comb begin
    dat_o_d = ack_d ? rdata : '0;
    cnt_d   = cnt_q + 1'b1;
  end

  always_ff @(posedge s_wb_clk_i or posedge s_wb_rst_i) begin
    if (s_wb_rst_i) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      dat_o_q <= '0;
      ack_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      dat_o_q <= dat_o_d;
      ack_q   <= ack_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign s_wb_ack_o = ack_q;
  assign s_wb_dat_o = dat_o_q;

endmodule

// File: tb/tb_jelly_wishbone_regfile.sv
// tb/tb_jelly_wishbone_regfile.sv - directed and randomized self-checking bench for jelly_wishbone_regfile
module tb_jelly_wishbone_regfile;

  localparam int          NR   = 8;
  localparam int          WC   = 2;
  localparam logic [31:0] IDV  = 32'h4A4C5246;
`ifdef JELLY_WB_REGFILE_ERR_EN
  localparam bit          ERR_EN = 1'b1;
`else
  localparam bit          ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [29:0] adr = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic [3:0]  sel = '0;
  logic        we = 1'b0;
  logic        stb = 1'b0;
  logic        ack;
  logic        err;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model [NR];

  always #5 clk = ~clk;

  jelly_wishbone_regfile dut (
    .s_wb_clk_i (clk),
    .s_wb_rst_i (rst),
    .s_wb_adr_i (adr),
    .s_wb_dat_o (dat_o),
    .s_wb_dat_i (dat_i),
    .s_wb_sel_i (sel),
    .s_wb_we_i  (we),
    .s_wb_stb_i (stb),
    .s_wb_ack_o (ack)
`ifdef JELLY_WB_REGFILE_ERR_EN
    ,
    .s_wb_err_o (err)
`endif
  );

`ifndef JELLY_WB_REGFILE_ERR_EN
  assign err = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    end
    return r;
  endfunction

  // One full transfer; returns the data seen on the response cycle and edges from stb to response
  task automatic xfer(input logic [29:0] a, input logic [31:0] d, input logic [3:0] s, input logic w,
                      output logic [31:0] rd, output int lat, output logic got_ack, output logic got_err);
    adr = a; dat_i = d; sel = s; we = w; stb = 1'b1;
    lat = 0; got_ack = 1'b0; got_err = 1'b0; rd = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (ack === 1'b1 || err === 1'b1) begin
        got_ack = ack; got_err = err; rd = dat_o;
        break;
      end
    end
    stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check("resp_single_cycle", {30'd0, ack, err}, 32'd0);
  endtask

  logic [31:0] rd, c1, c2;
  int          lat;
  logic        ga, ge;
  logic        seen;

  initial begin
    for (int i = 0; i < NR; i++) model[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ack", {31'd0, ack}, 32'd0);
    check("reset_dat", dat_o, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    xfer(30'd3, 32'h12345678, 4'hF, 1'b1, rd, lat, ga, ge);
    check("w3_latency", 32'(lat), 32'(WC + 1));
    check("w3_ack", {31'd0, ga}, 32'd1);
    model[3] = merge(model[3], 32'h12345678, 4'hF);
    xfer(30'd3, 32'h0, 4'hF, 1'b0, rd, lat, ga, ge);
    check("r3_data", rd, 32'h12345678);
    check("r3_latency", 32'(lat), 32'(WC + 1));

    xfer(30'd0, 32'hAABBCCDD, 4'h5, 1'b1, rd, lat, ga, ge);
    model[0] = merge(model[0], 32'hAABBCCDD, 4'h5);
    xfer(30'd0, 32'h0, 4'hF, 1'b0, rd, lat, ga, ge);
    check("r0_sel5", rd, 32'h00BB00DD);

    xfer(30'(NR + 1), 32'h0, 4'hF, 1'b0, rd, lat, ga, ge);
    check("id_word", rd, IDV);
    xfer(30'(NR), 32'h0, 4'hF, 1'b0, c1, lat, ga, ge);
    repeat (6) @(posedge clk);
    #1;
    xfer(30'(NR), 32'h0, 4'hF, 1'b0, c2, lat, ga, ge);
    check("cnt_delta", c2 - c1, 32'd10);

    adr = 30'd1; dat_i = 32'hFFFFFFFF; sel = 4'hF; we = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0; we = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack === 1'b1 || err === 1'b1) seen = 1'b1;
    end
    check("abort_no_ack", {31'd0, seen}, 32'd0);
    xfer(30'd1, 32'h0, 4'hF, 1'b0, rd, lat, ga, ge);
    check("abort_w1_unchanged", rd, model[1]);

    for (int n = 0; n < 40; n++) begin
      logic [29:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      logic        w, bad, e_ack, e_err;
      logic [31:0] e_rd;
      a = 30'($urandom_range(0, NR + 2));
      if ($urandom_range(0, 7) == 0) a = 30'd100;
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      w = 1'($urandom_range(0, 1));
      bad   = (a > 30'(NR + 1)) || (w && a >= 30'(NR));
      e_ack = ERR_EN ? !bad : 1'b1;
      e_err = ERR_EN ? bad : 1'b0;
      e_rd  = (a < 30'(NR)) ? model[a] : ((a == 30'(NR + 1)) ? IDV : 32'h0);
      xfer(a, d, s, w, rd, lat, ga, ge);
      check("rnd_latency", 32'(lat), 32'(WC + 1));
      check("rnd_ack_err", {30'd0, ga, ge}, {30'd0, e_ack, e_err});
      if (!w && a != 30'(NR) && e_ack) check("rnd_rdata", rd, e_rd);
      if (e_err) check("rnd_err_dat", rd, 32'h0);
      if (w && a < 30'(NR)) model[a] = merge(model[a], d, s);
    end

    adr = 30'd2; dat_i = 32'hDEADBEEF; sel = 4'hF; we = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_mid_ack", {31'd0, ack}, 32'd0);
    check("rst_mid_dat", dat_o, 32'd0);
    stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ack === 1'b1) seen = 1'b1;
    end
    check("rst_no_ack", {31'd0, seen}, 32'd0);
    for (int i = 0; i < NR; i++) model[i] = '0;
    for (int i = 0; i < NR; i++) begin
      xfer(30'(i), 32'h0, 4'hF, 1'b0, rd, lat, ga, ge);
      check("rst_reg_zero", rd, model[i]);
    end

    xfer(30'd100, 32'h0, 4'hF, 1'b0, rd, lat, ga, ge);
    check("unmapped_ack", {31'd0, ga}, {31'd0, !ERR_EN});
    check("unmapped_err", {31'd0, ge}, {31'd0, ERR_EN});
    check("unmapped_dat", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
